rfphoenix_icfill_ctrl: RTL and testbench
========================================

Name: rfphoenix_icfill_ctrl

Overview:
- Instruction-cache miss/refill sequencer for the rfPhoenix fetch unit.
- Samples the registered hit result of the tag-compare stage and, on a miss, stalls fetch, picks a victim way, and fetches the line as BEATS sequential memory beats.
- Writes the data, tag and valid bit into the cache arrays, and also sequences full-cache invalidation.

Parameters:
- LINES, 128, sets per way; index width log2(LINES)=7
- WAYS, 4, associativity; way select width 2
- AWID, 32, code address width
- BEAT_W, 128, memory beat width in bits
- BEATS, 4, beats per line; line = 512 bits (64 bytes), offset width 6
- HIT_LAT, 2, cycles from lookup_v/ip to valid ihit

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lookup_v  in  1  fetch lookup presented this cycle
- ip  in  AWID  fetch address for the lookup
- ihit  in  1  hit result, valid HIT_LAT cycles after lookup_v
- set_valid  in  WAYS  valid bits of the indexed set, aligned with ihit
- inv_req  in  1  pulse: invalidate entire cache
- mem_req  out  1  memory beat request
- mem_adr  out  AWID  beat address (beat-aligned)
- mem_ack  in  1  beat data valid
- mem_err  in  1  bus error, qualified by mem_ack
- mem_dat  in  BEAT_W  beat data
- wr_en  out  1  single-cycle array write strobe
- wr_way  out  2  way written
- wr_ndx  out  7  set index written
- wr_tag  out  AWID-6  tag written, ip[AWID-1:6]
- wr_line  out  BEAT_W*BEATS  assembled line
- wr_valid  out  1  valid bit value written
- stall  out  1  hold fetch
- fault  out  1  one-cycle pulse: refill bus error
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; beat counter=0; inv_pend=0; pipeline valid bits cleared.
- The block delays lookup_v and ip by HIT_LAT in a shift pipe. A miss is "pipe valid && !ihit" and is evaluated only in IDLE.
- stall is combinationally 1 when a miss is evaluated in IDLE, and stays 1 in every non-IDLE state.
- States and transitions:
  - IDLE
    - miss -> REQ. Latch miss_adr = pipe ip with the low 6 bits cleared; flush the pipe.
    - Else inv_req or inv_pend -> INV.
  - REQ
    - mem_req=1, mem_adr = miss_adr + beat*16.
    - mem_ack && !mem_err: store mem_dat into wr_line slice [beat]; if beat==BEATS-1 -> WRITE, else beat+1 and stay in REQ.
    - mem_req stays high continuously until the final ack.
  - mem_ack && mem_err: fault=1 for one cycle; no array write; -> IDLE with beat=0.
  - WRITE
    - wr_en=1, wr_valid=1, wr_ndx = miss_adr[12:6], wr_tag = miss_adr[AWID-1:6], wr_way = victim.
    - Then -> IDLE with beat=0.
    - The pipe restarts empty, so fetch re-presents the address.
  - INV
    - wr_en=1, wr_valid=0 for each way 0..WAYS-1 of each ndx 0..LINES-1, one write per cycle (LINES*WAYS cycles).
    - Way cycles fastest. wr_ndx and wr_way wrap together; -> IDLE after ndx=LINES-1, way=WAYS-1.
    - inv_pend cleared on entry.
- Victim choice, latched on entering REQ:
  - Lowest-numbered way with set_valid=0.
  - If all ways are valid, use rr_ptr, then rr_ptr = rr_ptr+1 mod WAYS.
  - rr_ptr advances only when it is used.
- Simultaneous events:
  - inv_req while not IDLE, or in the same cycle as a miss, sets inv_pend; the invalidation runs after the fill.
  - A miss and inv_pend together in IDLE: the miss wins.
- mem_ack outside REQ is ignored. rst mid-fill aborts immediately with no write.

Test Plan:
- Miss to an empty set, ip=0x0000_1234: mem_adr 0x1200, 0x1210, 0x1220, 0x1230 with acks -> one wr_en with wr_way=0, wr_ndx=0x48, wr_tag=0x48, wr_valid=1, and wr_line beat3 = 4th mem_dat. stall is high from miss evaluation until IDLE.
- set_valid=4'b1011 on a miss -> wr_way=2.
- Four misses with set_valid=4'b1111 -> wr_way sequence 0,1,2,3; fifth miss -> 0.
- mem_err on beat 2 -> fault pulses once, no wr_en, back to IDLE; the next miss restarts at beat 0.
- inv_req during a fill -> fill completes first, then 512 consecutive wr_en cycles with wr_valid=0; the last write has ndx=127, way=3.
- rst asserted in REQ after 2 beats -> all outputs 0 that cycle; after release, hit lookups produce no mem_req.

Source files
------------

// File: rtl/rfphoenix_icfill_if.sv
// Fetch, memory and array-write signals of the I-cache refill sequencer.
// master = the sequencer, slave = fetch unit / memory / cache arrays.
interface rfphoenix_icfill_if #(
  parameter int AWID   = 32,
  parameter int BEAT_W = 128,
  parameter int BEATS  = 4,
  parameter int WAYS   = 4,
  parameter int LINES  = 128
);
  localparam int OFFW = $clog2(BEAT_W / 8 * BEATS);
  localparam int NDXW = $clog2(LINES);
  localparam int WAYW = $clog2(WAYS);

  // Memory handshake: mem_req is held high until the beat is acknowledged;
  // a beat transfers on any cycle where mem_req && mem_ack, and mem_err is
  // only meaningful in that cycle.
  logic                      lookup_v;
  logic [AWID-1:0]           ip;
  logic                      ihit;
  logic [WAYS-1:0]           set_valid;
  logic                      inv_req;
  logic                      stall;
  logic                      fault;
  logic                      busy;
  logic [1:0]                dbg_state;
  logic                      mem_req;
  logic [AWID-1:0]           mem_adr;
  logic                      mem_ack;
  logic                      mem_err;
  logic [BEAT_W-1:0]         mem_dat;
  logic                      wr_en;
  logic [WAYW-1:0]           wr_way;
  logic [NDXW-1:0]           wr_ndx;
  logic [AWID-OFFW-1:0]      wr_tag;
  logic [BEAT_W*BEATS-1:0]   wr_line;
  logic                      wr_valid;

  modport master (
    input  lookup_v, ip, ihit, set_valid, inv_req, mem_ack, mem_err, mem_dat,
    output stall, fault, busy, dbg_state, mem_req, mem_adr,
           wr_en, wr_way, wr_ndx, wr_tag, wr_line, wr_valid
  );

  modport slave (
    output lookup_v, ip, ihit, set_valid, inv_req, mem_ack, mem_err, mem_dat,
    input  stall, fault, busy, dbg_state, mem_req, mem_adr,
           wr_en, wr_way, wr_ndx, wr_tag, wr_line, wr_valid
  );
endinterface

// File: rtl/rfphoenix_icfill_ctrl.sv
// I-cache miss/refill sequencer: detects a miss from the delayed hit result,
// fetches the line beat by beat, writes it to a victim way, and sequences invalidation.
module rfphoenix_icfill_ctrl #(
  parameter int LINES   = 128,
  parameter int WAYS    = 4,
  parameter int AWID    = 32,
  parameter int BEAT_W  = 128,
  parameter int BEATS   = 4,
  parameter int HIT_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  rfphoenix_icfill_if.master  bus
);
  localparam int BEAT_BYTES = BEAT_W / 8;
  localparam int BOFF       = $clog2(BEAT_BYTES);
  localparam int OFFW       = $clog2(BEAT_BYTES * BEATS);
  localparam int NDXW       = $clog2(LINES);
  localparam int WAYW       = $clog2(WAYS);
  localparam int BEATW      = $clog2(BEATS);
  localparam int INVW       = NDXW + WAYW;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WRITE = 2'd2, INV = 2'd3} state_e;

  state_e                  state_q;
  logic [HIT_LAT-1:0]      pipe_v_q;
  logic [AWID-1:0]         pipe_ip_q [HIT_LAT];
  logic [AWID-1:0]         miss_adr_q;
  logic [BEATW-1:0]        beat_q;
  logic [WAYW-1:0]         rr_ptr_q;
  logic [WAYW-1:0]         victim_q;
  logic [INVW-1:0]         inv_cnt_q;
  logic                    inv_pend_q;
  logic                    fault_q;
  logic [BEAT_W*BEATS-1:0] line_q;

  logic                    miss;
  logic [WAYW-1:0]         free_way;
  logic                    any_free;

  assign miss = (state_q == IDLE) && pipe_v_q[HIT_LAT-1] && !bus.ihit;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    free_way = '0;
    any_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!bus.set_valid[w]) begin
        free_way = WAYW'(w);
        any_free = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pipe_v_q   <= '0;
      for (int i = 0; i < HIT_LAT; i++) pipe_ip_q[i] <= '0;
      miss_adr_q <= '0;
      beat_q     <= '0;
      rr_ptr_q   <= '0;
      victim_q   <= '0;
      inv_cnt_q  <= '0;
      inv_pend_q <= 1'b0;
      fault_q    <= 1'b0;
      line_q     <= '0;
    end else begin
      fault_q <= 1'b0;

      if (bus.inv_req && (state_q != IDLE || miss)) inv_pend_q <= 1'b1;

      // Lookups only advance while idle; a miss or any busy state empties the pipe
      // so fetch must re-present its address afterwards.
      if (state_q != IDLE || miss) begin
        pipe_v_q <= '0;
      end else begin
        pipe_v_q[0]  <= bus.lookup_v;
        pipe_ip_q[0] <= bus.ip;
        for (int i = 1; i < HIT_LAT; i++) begin
          pipe_v_q[i]  <= pipe_v_q[i-1];
          pipe_ip_q[i] <= pipe_ip_q[i-1];
        end
      end

      case (state_q)
        IDLE: begin
          if (miss) begin
            state_q    <= REQ;
            miss_adr_q <= pipe_ip_q[HIT_LAT-1] & ~AWID'((1 << OFFW) - 1);
            beat_q     <= '0;
            if (any_free) begin
              victim_q <= free_way;
            end else begin
              victim_q <= rr_ptr_q;
              rr_ptr_q <= rr_ptr_q + 1'b1;
            end
          end else if (bus.inv_req || inv_pend_q) begin
            state_q    <= INV;
            inv_pend_q <= 1'b0;
            inv_cnt_q  <= '0;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            if (bus.mem_err) begin
              fault_q <= 1'b1;
              state_q <= IDLE;
              beat_q  <= '0;
            end else begin
              line_q[beat_q*BEAT_W +: BEAT_W] <= bus.mem_dat;
              if (beat_q == BEATW'(BEATS - 1)) begin
                state_q <= WRITE;
                beat_q  <= '0;
              end else begin
                beat_q <= beat_q + 1'b1;
              end
            end
          end
        end
        WRITE: state_q <= IDLE;
        INV: begin
          inv_cnt_q <= inv_cnt_q + 1'b1;
          if (inv_cnt_q == INVW'(LINES * WAYS - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall     = miss || (state_q != IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;
  assign bus.fault     = fault_q;
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_adr   = (state_q == REQ)
                       ? miss_adr_q + {{(AWID-BEATW-BOFF){1'b0}}, beat_q, {BOFF{1'b0}}}
                       : '0;
  assign bus.wr_en     = (state_q == WRITE) || (state_q == INV);
  assign bus.wr_valid  = (state_q == WRITE);
  // Invalidation counter: way in the low bits so it cycles fastest.
  assign bus.wr_way    = (state_q == WRITE) ? victim_q
                       : (state_q == INV)   ? inv_cnt_q[WAYW-1:0] : '0;
  assign bus.wr_ndx    = (state_q == WRITE) ? miss_adr_q[OFFW +: NDXW]
                       : (state_q == INV)   ? inv_cnt_q[INVW-1:WAYW] : '0;
  assign bus.wr_tag    = (state_q == WRITE) ? miss_adr_q[AWID-1:OFFW] : '0;
  assign bus.wr_line   = line_q;
endmodule

// File: tb/tb_rfphoenix_icfill_ctrl.sv
// Randomized scoreboard bench for the I-cache refill sequencer.
module tb_rfphoenix_icfill_ctrl;
  localparam int LINES = 128, WAYS = 4, AWID = 32, BEAT_W = 128, BEATS = 4, HIT_LAT = 2;

  typedef struct packed {
    logic         valid;
    logic [1:0]   way;
    logic [6:0]   ndx;
    logic [25:0]  tag;
    logic [511:0] line;
  } wr_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rfphoenix_icfill_if bus_if ();

  rfphoenix_icfill_ctrl #(
    .LINES(LINES), .WAYS(WAYS), .AWID(AWID), .BEAT_W(BEAT_W), .BEATS(BEATS), .HIT_LAT(HIT_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [AWID-1:0] exp_adr_q[$];
  wr_rec_t         exp_wr_q[$];
  int              exp_fault_n = 0;

  logic [BEAT_W-1:0] beat_dat [BEATS];
  int err_at    = -1;
  int ack_limit = BEATS;
  int beat_k    = 0;
  int rr        = 0;
  int inv_run   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference victim rule: first invalid way, else round-robin pointer that moves only when used.
  function automatic int pick_victim(input logic [3:0] sv);
    int v;
    for (int w = 0; w < WAYS; w++) if (!sv[w]) return w;
    v  = rr;
    rr = (rr + 1) % WAYS;
    return v;
  endfunction

  task automatic push_inv();
    wr_rec_t r;
    for (int n = 0; n < LINES; n++)
      for (int w = 0; w < WAYS; w++) begin
        r = '0;
        r.way = 2'(w);
        r.ndx = 7'(n);
        exp_wr_q.push_back(r);
      end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((bus_if.busy || exp_wr_q.size() != 0 || exp_adr_q.size() != 0 || exp_fault_n != 0)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 3000) begin
      miscompares++;
      $display("FAIL %s_drain: timeout with %0d writes %0d beats %0d faults outstanding, expected none",
               nm, exp_wr_q.size(), exp_adr_q.size(), exp_fault_n);
    end
    chk({nm, "_stall_idle"}, 64'(bus_if.stall), 64'd0);
  endtask

  // inv_mode: 0 none, 1 inv_req in the miss-evaluation cycle, 2 inv_req during the fill.
  task automatic do_miss(input logic [31:0] a, input logic [3:0] sv, input int eb, input int inv_mode);
    logic [31:0] base;
    wr_rec_t r;
    int nb;
    for (int b = 0; b < BEATS; b++) beat_dat[b] = {$urandom, $urandom, $urandom, $urandom};
    err_at = eb;
    base = a & ~32'h3f;
    nb = (eb < 0) ? BEATS : eb + 1;
    for (int b = 0; b < nb; b++) exp_adr_q.push_back(base + 32'(b * 16));
    r.way = 2'(pick_victim(sv));
    if (eb >= 0) begin
      exp_fault_n++;
    end else begin
      r.valid = 1'b1;
      r.ndx   = 7'((a >> 6) % LINES);
      r.tag   = 26'(a >> 6);
      r.line  = {beat_dat[3], beat_dat[2], beat_dat[1], beat_dat[0]};
      exp_wr_q.push_back(r);
    end
    if (inv_mode != 0) push_inv();

    @(posedge clk); #1;
    bus_if.lookup_v = 1'b1;
    bus_if.ip = a;
    @(posedge clk); #1;
    bus_if.lookup_v = 1'b0;
    bus_if.ip = $urandom;
    repeat (HIT_LAT - 1) @(posedge clk);
    #1;
    bus_if.ihit = 1'b0;
    bus_if.set_valid = sv;
    if (inv_mode == 1) bus_if.inv_req = 1'b1;
    #1 chk("stall_on_miss", 64'(bus_if.stall), 64'd1);
    @(posedge clk); #1;
    bus_if.ihit = 1'b1;
    bus_if.set_valid = 4'($urandom);
    bus_if.inv_req = (inv_mode == 2);
    @(posedge clk); #1;
    bus_if.inv_req = 1'b0;
    drain("miss");
  endtask

  task automatic do_hit(input logic [31:0] a);
    @(posedge clk); #1;
    bus_if.lookup_v = 1'b1;
    bus_if.ip = a;
    @(posedge clk); #1;
    bus_if.lookup_v = 1'b0;
    repeat (HIT_LAT - 1) @(posedge clk);
    #2 chk("stall_on_hit", 64'(bus_if.stall), 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stall"},   64'(bus_if.stall),   64'd0);
    chk({nm, "_busy"},    64'(bus_if.busy),    64'd0);
    chk({nm, "_mem_req"}, 64'(bus_if.mem_req), 64'd0);
    chk({nm, "_mem_adr"}, 64'(bus_if.mem_adr), 64'd0);
    chk({nm, "_wr_en"},   64'(bus_if.wr_en),   64'd0);
    chk({nm, "_fault"},   64'(bus_if.fault),   64'd0);
    chk({nm, "_wr_line"}, 64'(bus_if.wr_line == '0), 64'd1);
  endtask

  // Memory responder: random ack latency, stray acks while idle, optional error beat.
  initial begin
    bus_if.mem_ack = 1'b0;
    bus_if.mem_err = 1'b0;
    bus_if.mem_dat = '0;
    forever begin
      @(posedge clk); #1;
      bus_if.mem_ack = 1'b0;
      bus_if.mem_err = 1'b0;
      if (bus_if.mem_req) begin
        if (beat_k < ack_limit && $urandom_range(0, 2) != 0) begin
          bus_if.mem_ack = 1'b1;
          bus_if.mem_dat = beat_dat[beat_k];
          bus_if.mem_err = (beat_k == err_at);
          if (bus_if.mem_err || beat_k == BEATS - 1) beat_k = 0;
          else beat_k++;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus_if.mem_ack = 1'b1;
        bus_if.mem_err = 1'($urandom_range(0, 1));
        bus_if.mem_dat = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat, a write or a fault.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.busy) chk("stall_busy", 64'(bus_if.stall), 64'd1);
      if (bus_if.mem_req && bus_if.mem_ack) begin
        if (exp_adr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL mem_beat: got beat at %h, expected none", bus_if.mem_adr);
        end else begin
          chk("mem_adr", 64'(bus_if.mem_adr), 64'(exp_adr_q.pop_front()));
        end
      end
      if (bus_if.wr_en) begin
        if (exp_wr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL wr_unexp: got write v%0d way%0d ndx%h, expected none",
                   bus_if.wr_valid, bus_if.wr_way, bus_if.wr_ndx);
        end else begin
          wr_rec_t e;
          logic ok;
          e = exp_wr_q.pop_front();
          ok = (bus_if.wr_valid === e.valid) && (bus_if.wr_way === e.way) && (bus_if.wr_ndx === e.ndx);
          if (e.valid) ok = ok && (bus_if.wr_tag === e.tag) && (bus_if.wr_line === e.line);
          vectors++;
          if (!ok) begin
            miscompares++;
            $display("FAIL wr_rec: got v%0d way%0d ndx%h tag%h line_ok=%0d, expected v%0d way%0d ndx%h tag%h",
                     bus_if.wr_valid, bus_if.wr_way, bus_if.wr_ndx, bus_if.wr_tag,
                     bus_if.wr_line === e.line, e.valid, e.way, e.ndx, e.tag);
          end
        end
      end
      if (bus_if.fault) begin
        vectors++;
        if (exp_fault_n == 0) begin
          miscompares++;
          $display("FAIL fault_unexp: got fault=1, expected 0");
        end else begin
          exp_fault_n--;
        end
      end
      if (bus_if.wr_en && !bus_if.wr_valid) begin
        inv_run++;
      end else if (inv_run != 0) begin
        chk("inv_run_len", 64'(inv_run), 64'(LINES * WAYS));
        inv_run = 0;
      end
    end
  end

  initial begin
    bus_if.lookup_v  = 1'b0;
    bus_if.ip        = '0;
    bus_if.ihit      = 1'b1;
    bus_if.set_valid = '0;
    bus_if.inv_req   = 1'b0;
    for (int b = 0; b < BEATS; b++) beat_dat[b] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Directed cases
    do_miss(32'h0000_1234, 4'b0000, -1, 0);
    do_miss(32'h0000_5678, 4'b1011, -1, 0);
    for (int i = 0; i < 5; i++) do_miss($urandom, 4'b1111, -1, 0);
    do_miss(32'h0001_2340, 4'b0000, 2, 0);
    do_miss(32'h0001_2340, 4'b0001, -1, 0);
    do_miss(32'h00ab_cdc0, 4'b0111, -1, 2);
    do_hit(32'h0000_4000);

    // Randomized misses and hits
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) do_hit($urandom);
      do_miss($urandom, 4'($urandom_range(0, 15) | ($urandom_range(0, 1) ? 4'hf : 4'h0)),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1,
              (i == 12) ? 1 : 0);
    end

    // Standalone invalidation from idle
    push_inv();
    @(posedge clk); #1 bus_if.inv_req = 1'b1;
    @(posedge clk); #1 bus_if.inv_req = 1'b0;
    drain("inv");

    // Reset in the middle of a fill, after two beats
    ack_limit = 2;
    for (int b = 0; b < BEATS; b++) beat_dat[b] = {$urandom, $urandom, $urandom, $urandom};
    err_at = -1;
    exp_adr_q.push_back(32'h0000_2000);
    exp_adr_q.push_back(32'h0000_2010);
    @(posedge clk); #1 bus_if.lookup_v = 1'b1; bus_if.ip = 32'h0000_2008;
    @(posedge clk); #1 bus_if.lookup_v = 1'b0;
    repeat (HIT_LAT - 1) @(posedge clk);
    #1 bus_if.ihit = 1'b0; bus_if.set_valid = 4'b1111;
    @(posedge clk); #1 bus_if.ihit = 1'b1;
    begin
      int n = 0;
      while (!(bus_if.mem_req && bus_if.mem_adr == 32'h0000_2020) && n < 200) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (n >= 200) begin
        miscompares++;
        $display("FAIL rst_wait: beat 2 request not seen, expected within 200 cycles");
      end
    end
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_mid");
    @(posedge clk); #1;
    beat_k = 0;
    ack_limit = BEATS;
    rr = 0;
    rst = 1'b0;
    chk("rst_beats_seen", 64'(exp_adr_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) begin
      do_hit($urandom);
      chk("post_rst_no_req", 64'(bus_if.mem_req), 64'd0);
    end
    do_miss(32'h0000_3000, 4'b1111, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
